switch_calc_engine: RTL and testbench

//  Clocked, parametrised successor to the switch keyboard calculator. Operands A/B are

---
 rtl/switch_calc_engine.sv | 201 ++++++++++++++++++++
 tb/tb_switch_calc_engine.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_calc_engine.sv
// switch_calc_engine: switch-entry calculator with debounced commit strobe.
// Operands A/B are written nibble-by-nibble in entry mode. In compute mode a
// one-hot operation select is evaluated on each debounced commit edge.
module switch_calc_engine #(
   parameter  int unsigned NIBBLES    = 2,
   parameter  int unsigned DEB_CYCLES = 16,
   localparam int unsigned OPW        = 4 * NIBBLES + 1,
   localparam int unsigned RW         = OPW + 1,
   localparam int unsigned PW         = $clog2(NIBBLES)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          modesel,
   input  logic          sw_sign,
   input  logic          sw_alt,
   input  logic [PW-1:0] sw_pos,
   input  logic [3:0]    sw_nib,
   input  logic          sw_commit,
   output logic [RW-1:0] ans,
   output logic          ans_valid,
   output logic          error
);

   localparam int unsigned SW = PW + 8;
   localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
   localparam logic [PW:0]   NIB_LIM  = (PW + 1)'(NIBBLES);

   typedef enum logic [1:0] {
      ST_ENTRY,
      ST_ARMED,
      ST_DONE,
      ST_ERR
   } state_t;

   // ------------------------------------------------------------------
   // Input synchroniser and commit debounce
   // ------------------------------------------------------------------
   logic [SW-1:0] sync1_q, sync2_q;
   logic          lvl_q, lvl_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pulse_q, pulse_d;

   logic          mode_s, sign_s, alt_s, commit_s;
   logic [PW-1:0] pos_s;
   logic [3:0]    nib_s;

   assign {mode_s, sign_s, alt_s, pos_s, nib_s, commit_s} = sync2_q;

   // Two-flop synchroniser for every switch input
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= {modesel, sw_sign, sw_alt, sw_pos, sw_nib, sw_commit};
         sync2_q <= sync1_q;
      end
   end

   // Filter level flips after DEB_CYCLES consecutive mismatching cycles;
   // the strobe fires only on the flip towards 1
   always_comb begin
      lvl_d   = lvl_q;
      cnt_d   = '0;
      pulse_d = 1'b0;
      if (commit_s != lvl_q) begin
         if (cnt_q == DEB_LAST) begin
            lvl_d   = commit_s;
            pulse_d = commit_s;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Debounce state; level resets high so a held switch yields no strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lvl_q   <= 1'b1;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         lvl_q   <= lvl_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
      end
   end

   // ------------------------------------------------------------------
   // Operand store, compute datapath and mode FSM
   // ------------------------------------------------------------------
   state_t         state_q, state_d;
   logic [OPW-1:0] opa_q, opa_d, opb_q, opb_d;
   logic [RW-1:0]  ans_q, ans_d;
   logic           valid_q, valid_d;
   logic           err_q, err_d;

   logic [RW-1:0]  ext_a, ext_b, result;
   logic [5:0]     sel;
   logic           legal, pos_ok;

   function automatic logic [RW-1:0] sext(input logic [OPW-1:0] v);
      return {v[OPW-1], v};
   endfunction

   // Operation decode and result formation on sign-extended operands
   always_comb begin
      ext_a  = sext(opa_q);
      ext_b  = sext(opb_q);
      sel    = {sign_s, pos_s[0], nib_s};
      legal  = $onehot(sel) && ((pos_s >> 1) == '0);
      pos_ok = ({1'b0, pos_s} < NIB_LIM);
      result = '0;
      if (sel[5])      result = ext_a;
      else if (sel[4]) result = ext_b;
      else if (sel[3]) result = ext_a + ext_b;
      else if (sel[2]) result = ext_a & ext_b;
      else if (sel[1]) result = ext_a | ext_b;
      else if (sel[0]) result = ext_a ^ ext_b;
      if (alt_s) result = ~result;
   end

   // Next-state logic: entry writes operands, compute modes act on the strobe
   always_comb begin
      state_d = state_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      ans_d   = ans_q;
      valid_d = valid_q;
      err_d   = err_q;
      unique case (state_q)
         ST_ENTRY: begin
            ans_d = alt_s ? ext_b : ext_a;
            if (mode_s) begin
               state_d = ST_ARMED;
               valid_d = 1'b0;
               err_d   = 1'b0;
            end else if (pulse_q) begin
               if (pos_ok) begin
                  err_d = 1'b0;
                  for (int unsigned i = 0; i < NIBBLES; i++) begin
                     if (pos_s == PW'(i)) begin
                        if (alt_s) opb_d[4*i +: 4] = nib_s;
                        else       opa_d[4*i +: 4] = nib_s;
                     end
                  end
                  if (alt_s) opb_d[OPW-1] = sign_s;
                  else       opa_d[OPW-1] = sign_s;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_ARMED, ST_DONE, ST_ERR: begin
            // Leaving compute mode wins over a same-cycle strobe
            if (!mode_s) begin
               state_d = ST_ENTRY;
               valid_d = 1'b0;
               err_d   = 1'b0;
            end else if (pulse_q) begin
               if (legal) begin
                  state_d = ST_DONE;
                  ans_d   = result;
                  valid_d = 1'b1;
                  err_d   = 1'b0;
               end else begin
                  state_d = ST_ERR;
                  valid_d = 1'b0;
                  err_d   = 1'b1;
               end
            end
         end
         default: state_d = ST_ENTRY;
      endcase
   end

   // Datapath and FSM registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_ENTRY;
         opa_q   <= '0;
         opb_q   <= '0;
         ans_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         ans_q   <= ans_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign ans       = ans_q;
   assign ans_valid = valid_q;
   assign error     = err_q;

endmodule

// File: tb/tb_switch_calc_engine.sv
// Directed bench for switch_calc_engine with NIBBLES=2, DEB_CYCLES=4.
module tb_switch_calc_engine;

   localparam int NIB = 2;
   localparam int DEB = 4;
   localparam int OPW = 4 * NIB + 1;
   localparam int RW  = OPW + 1;

   typedef struct packed {
      logic [RW-1:0] ans;
      logic          valid;
      logic          err;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          modesel = 1'b0;
   logic          sw_sign = 1'b0;
   logic          sw_alt = 1'b0;
   logic [0:0]    sw_pos = '0;
   logic [3:0]    sw_nib = '0;
   logic          sw_commit = 1'b0;
   logic [RW-1:0] ans;
   logic          ans_valid;
   logic          error;

   int            checks = 0;
   int            failures = 0;

   exp_t          sb_q[$];
   string         tag_q[$];

   logic [OPW-1:0] m_a = '0;
   logic [OPW-1:0] m_b = '0;
   logic [RW-1:0]  m_ans = '0;

   switch_calc_engine #(.NIBBLES(NIB), .DEB_CYCLES(DEB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .modesel   (modesel),
      .sw_sign   (sw_sign),
      .sw_alt    (sw_alt),
      .sw_pos    (sw_pos),
      .sw_nib    (sw_nib),
      .sw_commit (sw_commit),
      .ans       (ans),
      .ans_valid (ans_valid),
      .error     (error)
   );

   always #5 clk = ~clk;

   function automatic logic [RW-1:0] m_sext(input logic [OPW-1:0] v);
      logic [RW-1:0] r;
      r = {{(RW-OPW){v[OPW-1]}}, v};
      return r;
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic sb_push(input string tag, input logic [RW-1:0] a, input logic v, input logic e);
      exp_t x;
      x.ans = a;
      x.valid = v;
      x.err = e;
      sb_q.push_back(x);
      tag_q.push_back(tag);
      m_ans = a;
   endtask

   task automatic sb_pop_check();
      exp_t  x;
      string t;
      if (sb_q.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
         x = sb_q.pop_front();
         t = tag_q.pop_front();
         check({t, "_ans"}, ans, x.ans);
         check({t, "_valid"}, RW'(ans_valid), RW'(x.valid));
         check({t, "_err"}, RW'(error), RW'(x.err));
      end
   endtask

   task automatic do_commit();
      sw_commit = 1'b1;
      cyc(DEB + 6);
      sw_commit = 1'b0;
      cyc(DEB + 6);
   endtask

   task automatic entry_write(input string tag, input logic alt, input logic sign,
                              input int pos, input logic [3:0] nib);
      sw_alt = alt; sw_sign = sign; sw_pos = 1'(pos); sw_nib = nib;
      if (alt) begin
         m_b[4*pos +: 4] = nib;
         m_b[OPW-1] = sign;
         sb_push(tag, m_sext(m_b), 1'b0, 1'b0);
      end else begin
         m_a[4*pos +: 4] = nib;
         m_a[OPW-1] = sign;
         sb_push(tag, m_sext(m_a), 1'b0, 1'b0);
      end
      do_commit();
      sb_pop_check();
   endtask

   function automatic logic [RW-1:0] m_calc(input logic [3:0] nib, input logic sign,
                                             input logic pos, input logic alt);
      logic [RW-1:0] ea, eb, r;
      ea = m_sext(m_a);
      eb = m_sext(m_b);
      r = '0;
      if (sign)        r = ea;
      else if (pos)    r = eb;
      else if (nib[3]) r = ea + eb;
      else if (nib[2]) r = ea & eb;
      else if (nib[1]) r = ea | eb;
      else if (nib[0]) r = ea ^ eb;
      return alt ? ~r : r;
   endfunction

   task automatic compute(input string tag, input logic alt, input logic sign,
                          input logic pos, input logic [3:0] nib);
      int n;
      sw_alt = alt; sw_sign = sign; sw_pos = pos; sw_nib = nib;
      n = int'(sign) + int'(pos) + int'(nib[0]) + int'(nib[1]) + int'(nib[2]) + int'(nib[3]);
      if (n == 1) sb_push(tag, m_calc(nib, sign, pos, alt), 1'b1, 1'b0);
      else        sb_push(tag, m_ans, 1'b0, 1'b1);
      do_commit();
      sb_pop_check();
   endtask

   initial begin
      // reset state
      cyc(2);
      check("rst_ans", ans, '0);
      check("rst_valid", RW'(ans_valid), '0);
      check("rst_err", RW'(error), '0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(DEB + 6);
      check("post_rst_ans", ans, '0);

      // operand entry
      entry_write("a_hi", 1'b0, 1'b0, 1, 4'h3);
      entry_write("a_lo", 1'b0, 1'b0, 0, 4'h5);
      check("opa_035", ans, 10'h035);
      entry_write("b_hi", 1'b1, 1'b1, 1, 4'hF);
      entry_write("b_lo", 1'b1, 1'b1, 0, 4'hF);
      check("opb_1ff", ans, 10'h3FF);

      // compute ADD with exact commit latency
      modesel = 1'b1;
      sw_alt = 1'b0; sw_sign = 1'b0; sw_pos = '0; sw_nib = 4'b1000;
      cyc(4);
      check("armed_valid", RW'(ans_valid), '0);
      sb_push("add", m_calc(4'b1000, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0);
      sw_commit = 1'b1;
      cyc(2 + DEB);
      check("lat_early_valid", RW'(ans_valid), '0);
      cyc(1);
      sb_pop_check();
      check("add_034", ans, 10'h034);
      sw_commit = 1'b0;
      cyc(DEB + 6);

      // bitwise, display and inversion variants
      compute("and_inv", 1'b1, 1'b0, 1'b0, 4'b0100);
      check("and_inv_3ca", ans, 10'h3CA);
      compute("xor", 1'b0, 1'b0, 1'b0, 4'b0001);
      compute("or", 1'b0, 1'b0, 1'b0, 4'b0010);
      compute("dispa", 1'b0, 1'b1, 1'b0, 4'b0000);
      compute("dispb", 1'b0, 1'b0, 1'b1, 4'b0000);

      // illegal selects hold ans and flag error
      compute("ill_add_xor", 1'b0, 1'b0, 1'b0, 4'b1001);
      compute("ill_none", 1'b0, 1'b0, 1'b0, 4'b0000);
      compute("recover_dispa", 1'b1, 1'b1, 1'b0, 4'b0000);
      compute("ill_sign_b", 1'b0, 1'b1, 1'b1, 4'b0000);
      modesel = 1'b0;
      sw_alt = 1'b0;
      cyc(6);
      check("exit_err", RW'(error), '0);
      check("exit_valid", RW'(ans_valid), '0);
      check("exit_preview", ans, m_sext(m_a));

      // bouncing commit yields exactly one write
      sw_alt = 1'b1; sw_sign = 1'b0; sw_pos = '0; sw_nib = 4'hA;
      for (int i = 0; i < 5; i++) begin
         sw_commit = 1'b1; cyc(2);
         sw_commit = 1'b0; cyc(2);
      end
      check("bounce_nowrite", ans, m_sext(m_b));
      m_b[3:0] = 4'hA;
      m_b[OPW-1] = 1'b0;
      sb_push("bounce_write", m_sext(m_b), 1'b0, 1'b0);
      do_commit();
      sb_pop_check();

      // reset while DONE with commit held through release
      modesel = 1'b1;
      sw_alt = 1'b0; sw_sign = 1'b0; sw_pos = '0; sw_nib = 4'b1000;
      cyc(4);
      sw_commit = 1'b1;
      cyc(DEB + 6);
      check("pre_rst_done", RW'(ans_valid), 1);
      check("pre_rst_ans", ans, m_calc(4'b1000, 1'b0, 1'b0, 1'b0));
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_ans", ans, '0);
      check("async_rst_valid", RW'(ans_valid), '0);
      modesel = 1'b0; sw_nib = 4'hF;
      m_a = '0; m_b = '0; m_ans = '0;
      @(negedge clk);
      rst_n = 1'b1;
      cyc(DEB + 10);
      check("held_commit_ans", ans, '0);
      check("held_commit_valid", RW'(ans_valid), '0);
      check("held_commit_err", RW'(error), '0);
      sw_alt = 1'b1;
      cyc(4);
      check("rst_opb_zero", ans, '0);
      sw_commit = 1'b0;
      cyc(DEB + 6);
      entry_write("post_rst_write", 1'b0, 1'b0, 0, 4'h7);

      if (sb_q.size() != 0) begin
         checks++;
         failures++;
         $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
